// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2,
      HALT    = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam logic [31:0] PC_STEP       = 32'd4;
   localparam int unsigned DEPTH_DEFAULT = 2;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Memory, redirect and consumer signals of the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic        misalign_err;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc, op, funct, misalign_err,
      input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, op, funct, misalign_err,
      output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
   );
endinterface
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Two-entry instruction FIFO with flush; no write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output logic [1:0]   count,
   output fetch_entry_t head
);
   localparam logic [1:0] c_depth = 2'(DEPTH);

   fetch_entry_t r_mem [2];
   logic         r_wptr;
   logic         r_rptr;
   logic [1:0]   r_count;
   logic         w_pop;
   logic         w_push;

   assign w_pop  = pop & (r_count != 2'd0);
   assign w_push = push & ((r_count != c_depth) | w_pop);

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_push) r_wptr <= ~r_wptr;
         if (w_pop)  r_rptr <= ~r_rptr;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= din;
   end

   assign count = r_count;
   assign head  = r_mem[r_rptr];
endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch FSM with 2-entry buffer and redirect flush.
//               Optional FETCH_ALIGN_CHECK_EN halts on misaligned redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = DEPTH_DEFAULT
) (
   input  logic          clk,
   input  logic          reset_n,
   instr_fetch_if.master bus
);
   localparam logic [1:0] c_depth = 2'(DEPTH);

   fetch_state_t r_state;
   logic         r_req;
   logic         r_err;
   logic [31:0]  r_addr;
   logic [31:0]  r_pc;
   logic [1:0]   w_count;
   fetch_entry_t w_head;
   fetch_entry_t w_din;
   logic         w_ack;
   logic         w_valid;
   logic         w_pop;
   logic         w_push;
   logic         w_full_next;
   logic         w_misalign;
   logic [31:0]  w_tgt;
   logic [31:0]  w_instr;

`ifdef FETCH_ALIGN_CHECK_EN
   assign w_tgt      = bus.redirect_pc;
   assign w_misalign = bus.redirect & (bus.redirect_pc[1:0] != 2'b00);
`else
   assign w_tgt      = bus.redirect_pc & ~32'h3;
   assign w_misalign = 1'b0;
`endif

   // An ack only counts against a request this unit is currently presenting.
   assign w_ack       = bus.imem_ack & r_req;
   assign w_valid     = (w_count != 2'd0);
   assign w_pop       = w_valid & bus.instr_ready;
   assign w_push      = w_ack & (r_state == FETCH) & ~bus.redirect;
   assign w_full_next = w_push & ~w_pop & ((w_count + 2'd1) >= c_depth);
   assign w_din       = '{pc: r_addr, instr: bus.imem_rdata};

   fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (w_push),
      .pop     (w_pop),
      .flush   (bus.redirect),
      .din     (w_din),
      .count   (w_count),
      .head    (w_head)
   );

   // r_addr is what is on the bus; r_pc is the next target, which diverges
   // from r_addr only while DISCARD waits for the abandoned request's ack.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= FETCH;
         r_req   <= 1'b0;
         r_err   <= 1'b0;
         r_addr  <= RESET_PC;
         r_pc    <= RESET_PC;
      end else if (r_state == HALT) begin
         r_req <= 1'b0;
      end else if (w_misalign) begin
         r_state <= HALT;
         r_req   <= 1'b0;
         r_err   <= 1'b1;
      end else if (bus.redirect) begin
         r_pc  <= w_tgt;
         r_req <= 1'b1;
         if (r_req && !bus.imem_ack) begin
            r_state <= DISCARD;
         end else begin
            r_state <= FETCH;
            r_addr  <= w_tgt;
         end
      end else begin
         case (r_state)
            FETCH: begin
               if (w_ack) begin
                  r_addr <= r_addr + PC_STEP;
                  r_pc   <= r_addr + PC_STEP;
                  if (w_full_next) begin
                     r_state <= HOLD;
                     r_req   <= 1'b0;
                  end else begin
                     r_req   <= 1'b1;
                  end
               end else begin
                  r_req <= 1'b1;
               end
            end
            HOLD: begin
               if (w_pop) begin
                  r_state <= FETCH;
                  r_req   <= 1'b1;
               end
            end
            DISCARD: begin
               if (w_ack) begin
                  r_state <= FETCH;
                  r_addr  <= r_pc;
               end
            end
            default: begin
               r_state <= FETCH;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   assign w_instr          = w_valid ? w_head.instr : 32'h0;
   assign bus.imem_req     = r_req;
   assign bus.imem_addr    = r_addr;
   assign bus.instr_valid  = w_valid;
   assign bus.instr        = w_instr;
   assign bus.instr_pc     = w_valid ? w_head.pc : 32'h0;
   assign bus.op           = w_instr[31:26];
   assign bus.funct        = w_instr[5:0];
   assign bus.misalign_err = r_err;
endmodule
`default_nettype wire
